bit_select_sequential: RTL and testbench

Rank/select counterpart of the integer population-count block. Given an operand word and a zero-based rank k, it returns the bit index of the k-th set bit, counted from the LSB, and reports whether that bit exists. It scans one byte per cycle using per-byte population counts, behind a valid/ready input handshake and a single-cycle result strobe. It sits in the Integer/Miscellaneous bit-manipulation group, under the sequential variants.

---
 rtl/bit_select_pkg.sv | 20 ++
 rtl/byte_bit_select.sv | 31 +++
 rtl/bit_select_sequential.sv | 112 +++++++++++
 tb/tb_bit_select_sequential.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_select_pkg.sv
// rtl/bit_select_pkg.sv - shared types and constants for the sequential bit-select block
package bit_select_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int INDEX_WIDTH        = $clog2(DATA_WIDTH_DEFAULT);
  localparam int BYTE_COUNT_WIDTH   = 4;

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  localparam bit DATA_WIDTH_IS_POW2 = is_pow2(DATA_WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

endpackage

// File: rtl/byte_bit_select.sv
// rtl/byte_bit_select.sv - popcount of one byte and position of its rank-th set bit
module byte_bit_select
  import bit_select_pkg::*;
(
  input  logic [7:0]                  byte_i,
  input  logic [2:0]                  rank_i,
  output logic [BYTE_COUNT_WIDTH-1:0] count_o,
  output logic                        hit_o,
  output logic [2:0]                  pos_o
);

  logic [BYTE_COUNT_WIDTH-1:0] seen;

  always_comb begin
    count_o = '0;
    seen    = '0;
    pos_o   = '0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {{(BYTE_COUNT_WIDTH-1){1'b0}}, byte_i[i]};
      if (byte_i[i]) begin
        if (seen == {1'b0, rank_i}) begin
          pos_o = 3'(i);
        end
        seen = seen + 1'b1;
      end
    end
  end

  assign hit_o = {1'b0, rank_i} < count_o;

endmodule

// File: rtl/bit_select_sequential.sv
// rtl/bit_select_sequential.sv - index of the k-th set bit, scanning one byte per cycle
module bit_select_sequential
  import bit_select_pkg::*;
#(
  parameter  int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  localparam int BYTES_NUMBER = DATA_WIDTH / 8,
  localparam int IW           = $clog2(DATA_WIDTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [BYTES_NUMBER-1:0][7:0] operand_i,
  input  logic [IW-1:0]                rank_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [IW-1:0]                index_o,
  output logic                         found_o,
  output logic                         valid_o
);

  localparam int PW = (BYTES_NUMBER > 1) ? $clog2(BYTES_NUMBER) : 1;
  localparam int CW = (IW > BYTE_COUNT_WIDTH) ? IW : BYTE_COUNT_WIDTH;

  if (!is_pow2(DATA_WIDTH) || (DATA_WIDTH < 8)) begin : g_bad_width
    $error("bit_select_sequential: DATA_WIDTH must be a power of 2 and at least 8");
  end

  state_e                       state_q;
  logic [BYTES_NUMBER-1:0][7:0] operand_q;
  logic [IW-1:0]                rem_q;
  logic [PW-1:0]                ptr_q;
  logic [IW-1:0]                index_q;
  logic                         found_q;
  logic                         valid_q;

  logic [7:0]                  cur_byte;
  logic [BYTE_COUNT_WIDTH-1:0] byte_count;
  logic                        byte_hit;
  logic [2:0]                  byte_pos;
  logic [CW-1:0]               rem_ext;
  logic [CW-1:0]               cnt_ext;
  logic                        scan_hit;
  logic                        last_byte;

  assign cur_byte = operand_q[ptr_q];

  byte_bit_select u_byte_bit_select (
    .byte_i  (cur_byte),
    .rank_i  (rem_q[2:0]),
    .count_o (byte_count),
    .hit_o   (byte_hit),
    .pos_o   (byte_pos)
  );

  // The byte helper only sees the low rank bits, so a hit also needs remaining < 8.
  assign rem_ext   = CW'(rem_q);
  assign cnt_ext   = CW'(byte_count);
  assign scan_hit  = byte_hit && (rem_ext < CW'(8));
  assign last_byte = (ptr_q == PW'(BYTES_NUMBER - 1));

  assign ready_o = (state_q == IDLE) && !rst_i;
  assign index_o = index_q;
  assign found_o = found_q;
  assign valid_o = valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      operand_q <= '0;
      rem_q     <= '0;
      ptr_q     <= '0;
      index_q   <= '0;
      found_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            operand_q <= operand_i;
            rem_q     <= rank_i;
            ptr_q     <= '0;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            index_q <= IW'({ptr_q, byte_pos});
            found_q <= 1'b1;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else if (last_byte) begin
            index_q <= '0;
            found_q <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            // Only reached when remaining >= count, so this never wraps.
            rem_q <= IW'(rem_ext - cnt_ext);
            ptr_q <= ptr_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_select_sequential.sv
// tb/tb_bit_select_sequential.sv - randomized self-checking bench for bit_select_sequential
module tb_bit_select_sequential;

  localparam int DW = 32;
  localparam int BN = DW / 8;
  localparam int IW = $clog2(DW);

  logic               clk;
  logic               rst;
  logic [BN-1:0][7:0] operand;
  logic [IW-1:0]      rank;
  logic               valid_in;
  logic               ready;
  logic [IW-1:0]      index;
  logic               found;
  logic               valid_out;

  int checks = 0;
  int errors = 0;

  bit rst_at_edge = 1'b1;
  bit checking    = 1'b0;
  bit pending     = 1'b0;
  int wait_cnt    = 0;
  int pend_idx    = 0;
  bit pend_fnd    = 1'b0;
  int held_idx    = 0;
  bit held_fnd    = 1'b0;

  bit_select_sequential #(.DATA_WIDTH(DW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .operand_i (operand),
    .rank_i    (rank),
    .valid_i   (valid_in),
    .ready_o   (ready),
    .index_o   (index),
    .found_o   (found),
    .valid_o   (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk the bits from LSB, counting ones until the rank-th one.
  function automatic void ref_select(input logic [DW-1:0] op, input int rk,
                                     output int idx, output bit fnd);
    int seen;
    seen = 0;
    idx  = 0;
    fnd  = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (op[i]) begin
        if (seen == rk && !fnd) begin
          idx = i;
          fnd = 1'b1;
        end
        seen++;
      end
    end
  endfunction

  always @(posedge clk) begin
    rst_at_edge = rst;
    if (rst) checking = 1'b1;
  end

  // Compare process: every cycle, outputs vs. the model's expectations.
  always @(negedge clk) begin
    bit ev;
    bit er;
    if (checking) begin
      if (rst_at_edge) begin
        pending  = 1'b0;
        held_idx = 0;
        held_fnd = 1'b0;
      end else if (pending) begin
        wait_cnt--;
      end
      ev = pending && (wait_cnt == 0);
      er = !pending && !rst;
      check("valid_o", int'(valid_out), int'(ev));
      check("ready_o", int'(ready), int'(er));
      if (ev) begin
        held_idx = pend_idx;
        held_fnd = pend_fnd;
        pending  = 1'b0;
      end
      check("index_o", int'(index), held_idx);
      check("found_o", int'(found), int'(held_fnd));
      if (er && valid_in) begin
        ref_select(operand, int'(rank), pend_idx, pend_fnd);
        wait_cnt = (pend_fnd ? pend_idx / 8 : BN - 1) + 2;
        pending  = 1'b1;
      end
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < 30 && !ok; n++) begin
      if (ready) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL wait_ready: got ready_o 0 expected 1 within 30 cycles");
    end
  endtask

  task automatic run_op(input logic [DW-1:0] op, input int rk, input int exp_lat,
                        input int exp_idx, input bit exp_fnd, input bit noise);
    bit seen;
    int lat;
    wait_ready();
    operand  = op;
    rank     = IW'(rk);
    valid_in = 1'b1;
    @(posedge clk); #1;
    if (!noise) valid_in = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (valid_out) begin
        seen = 1'b1;
        lat  = n;
        check("dir_latency", lat, exp_lat);
        check("dir_index", int'(index), exp_idx);
        check("dir_found", int'(found), int'(exp_fnd));
      end else begin
        @(posedge clk); #1;
        if (noise) begin
          operand = $urandom;
          rank    = IW'($urandom_range(0, DW - 1));
        end
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL dir_timeout: got no valid_o expected one within 20 cycles");
    end
    if (noise) begin
      @(posedge clk); #1;
      check("b2b_ready_after_done", int'(ready), 1);
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic random_op();
    logic [DW-1:0] op;
    int            kind;
    int            gap;
    kind = $urandom_range(0, 5);
    case (kind)
      0: op = '0;
      1: op = '1;
      2: op = DW'(1) << $urandom_range(0, DW - 1);
      3: op = $urandom & $urandom & $urandom;
      default: op = $urandom;
    endcase
    wait_ready();
    operand  = op;
    rank     = IW'(($urandom_range(0, 1) == 0) ? $urandom_range(0, DW - 1)
                                               : $urandom_range(0, $countones(op)));
    valid_in = 1'b1;
    @(posedge clk); #1;
    gap = $urandom_range(0, 7);
    for (int n = 0; n < gap; n++) begin
      valid_in = ($urandom_range(0, 2) == 0);
      operand  = $urandom;
      rank     = IW'($urandom_range(0, DW - 1));
      if ($urandom_range(0, 40) == 0) rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    valid_in = 1'b0;
  endtask

  initial begin
    int  m_idx;
    bit  m_fnd;
    rst      = 1'b1;
    valid_in = 1'b0;
    operand  = '0;
    rank     = '0;

    ref_select(32'hF0F0_F0F0, 5, m_idx, m_fnd);
    check("model_f0f0_r5_idx", m_idx, 13);
    check("model_f0f0_r5_fnd", int'(m_fnd), 1);
    ref_select(32'h8000_0000, 0, m_idx, m_fnd);
    check("model_msb_idx", m_idx, 31);
    ref_select(32'h0000_00FF, 8, m_idx, m_fnd);
    check("model_ff_r8_fnd", int'(m_fnd), 0);
    ref_select(32'hFFFF_FFFF, 31, m_idx, m_fnd);
    check("model_ones_r31_idx", m_idx, 31);

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", int'(ready), 0);
    check("reset_valid", int'(valid_out), 0);
    check("reset_index", int'(index), 0);
    check("reset_found", int'(found), 0);
    rst = 1'b0;

    run_op(32'h0000_0001,  0, 2,  0, 1'b1, 1'b0);
    run_op(32'h8000_0000,  0, 5, 31, 1'b1, 1'b0);
    run_op(32'hF0F0_F0F0,  5, 3, 13, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 31, 5, 31, 1'b1, 1'b0);
    run_op(32'h0000_00FF,  8, 5,  0, 1'b0, 1'b0);
    run_op(32'h0000_0000,  0, 5,  0, 1'b0, 1'b0);
    run_op(32'h8000_0000,  0, 5, 31, 1'b1, 1'b1);

    // Reset during the second SCAN cycle aborts the operation.
    wait_ready();
    operand  = 32'h8000_0000;
    rank     = '0;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_in_reset", int'(ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", int'(ready), 1);
    check("abort_index", int'(index), 0);
    check("abort_found", int'(found), 0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("abort_no_valid", int'(valid_out), 0);
    end

    for (int i = 0; i < 300; i++) random_op();

    repeat (12) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
